cs_result_buffer: RTL and testbench
===================================

Name: cs_result_buffer

Overview:
- Downstream stage of the CS computational system; consumes the 10-bit Y result stream.
- Discards the warm-up results produced before the 9-sample window is full.
- Buffers valid results in a small FIFO and hands them to the consumer over a valid/ready interface.
- Also tracks peak result, accepted count and a sticky overflow flag for test/debug.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, FIFO pointer width = log2(DEPTH).
- WARMUP, 8, number of enabled samples discarded after reset.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-low; reset==0 at a posedge clears all state.
- Y  input  10  CS result; CS updates it on negedge, so it is stable at posedge.
- y_en  input  1  high when Y carries a new result this cycle.
- dout  output  10  FIFO head data.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready at posedge.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- peak  output  10  maximum Y accepted into the FIFO since reset.
- ovf  output  1  sticky, set when an accepted-phase sample is dropped because the FIFO is full.
- warm  output  1  high while still discarding warm-up samples.

Behaviour:
- Reset (reset==0 at posedge):
  - Pointers = 0; count = 0; dout_valid = 0; dout = 0.
  - peak = 0; ovf = 0; warm = 1; warm-up counter = 0.
  - Reset overrides every other event in the same cycle, including push/pop mid-operation.
- Warm-up phase (warm==1):
  - Each posedge with y_en==1 increments the warm-up counter; Y is not stored.
  - When the counter reaches WARMUP, warm drops to 0 at that same edge. The WARMUP-th sample is also discarded.
  - y_en==0 cycles do not count.
- Push:
  - push = y_en && !warm && (count<DEPTH || pop).
  - Y is written at the write pointer; the write pointer increments modulo DEPTH and wraps naturally.
- Pop:
  - pop = dout_valid && dout_ready.
  - The read pointer increments modulo DEPTH.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full; count is unchanged.
  - When full, the popped slot is the one overwritten. This is legal because read precedes write in slot order.
- Overflow:
  - y_en && !warm && count==DEPTH && !pop: sample dropped, ovf set to 1 and held until reset. FIFO contents are unchanged.
- Empty:
  - dout_valid = 0; dout holds the last head value (don't-care for checking).
  - dout_ready while empty has no effect.
- Latency:
  - No bypass. A sample pushed at edge N is visible on dout/dout_valid after edge N, i.e. usable at edge N+1.
  - dout is registered (head register or registered memory read). It must show the new head the cycle after a pop.
- Output relations:
  - count = writes − reads; dout_valid = (count!=0).
  - All outputs are registered; no combinational path from dout_ready to dout_valid.
- peak:
  - Updated only on a push: if Y > peak then peak <= Y.
  - Dropped and warm-up samples never affect peak.
- Width: Y is full 10-bit unsigned, maximum 1023; no truncation anywhere.

Test Plan:
1. Reset low 2 cycles, then y_en=1 with Y=1..8 → nothing stored; warm falls after the 8th; count=0, peak=0, dout_valid=0.
2. After warm-up, push Y=100,200,50 with dout_ready=0 → count=3, dout=100, peak=200. Then dout_ready=1 for 3 cycles → dout sequence 100,200,50; count=0.
3. With dout_ready=0, push 9 samples Y=10..18 → count=8, ovf=1, FIFO holds 10..17. Drain → 10..17 in order; ovf stays 1.
4. Fill to 8, then one cycle with y_en=1, Y=999 and dout_ready=1 → count stays 8, ovf stays 0, head becomes 11, 999 is the last entry; peak=999.
5. Stream 20 samples with dout_ready=1 continuously → pointers wrap; every Y appears on dout exactly once, in order, one cycle after push; count never exceeds 1.
6. Apply reset=0 mid-stream with count=5 and ovf=1 → next cycle count=0, dout_valid=0, ovf=0, peak=0, warm=1. The next 8 y_en samples are discarded again.

Source files
------------

// File: rtl/cs_result_buffer.sv
// Result buffer for the CS 10-bit Y stream: drops warm-up samples, queues valid results
// in a small FIFO with a registered head, and tracks peak, occupancy and overflow.
module cs_result_buffer #(
   parameter int DEPTH  = 8,
   parameter int AW     = 3,
   parameter int WARMUP = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    Y,
   input  logic          y_en,
   output logic [9:0]    dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [AW:0]   count,
   output logic [9:0]    peak,
   output logic          ovf,
   output logic          warm
);

   localparam int              WCW       = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
   localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);
   localparam logic [WCW-1:0]  WARM_LAST = WCW'(WARMUP - 1);

   logic [9:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  rd_next;
   logic [WCW-1:0] warm_cnt;
   logic           full;
   logic           push;
   logic           pop;
   logic           drop;
   logic [AW:0]    count_next;
   logic [9:0]     head_next;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      full       = (count == FULL_CNT);
      pop        = dout_valid && dout_ready;
      push       = y_en && !warm && (!full || pop);
      drop       = y_en && !warm && full && !pop;
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
      rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
      // The next head is the incoming sample when it lands in the slot the head moves to.
      head_next = (push && (wr_ptr == rd_next)) ? Y : mem[rd_next];
   end

   // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= Y;
   end

   // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         dout       <= '0;
         peak       <= '0;
         ovf        <= 1'b0;
         warm       <= 1'b1;
         warm_cnt   <= '0;
      end else begin
         if (warm && y_en) begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WARM_LAST)
               warm <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (Y > peak)
               peak <= Y;
         end
         rd_ptr     <= rd_next;
         count      <= count_next;
         dout_valid <= (count_next != '0);
         if (count_next != '0)
            dout <= head_next;
         if (drop)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cs_result_buffer.sv
// Directed bench for cs_result_buffer: warm-up, FIFO order, overflow, full push/pop,
// streaming wrap-around and mid-stream reset.
module tb_cs_result_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] Y;
   logic       y_en;
   logic [9:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [3:0] count;
   logic [9:0] peak;
   logic       ovf;
   logic       warm;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cs_result_buffer #(.DEPTH(8), .AW(3), .WARMUP(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .Y          (Y),
      .y_en       (y_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .peak       (peak),
      .ovf        (ovf),
      .warm       (warm)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0; y_en = 1'b0; dout_ready = 1'b0; Y = '0;
      step(); step();
      reset = 1'b1;
   endtask

   task automatic run_warmup();
      y_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         Y = 10'(i);
         step();
      end
      y_en = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", dout_valid); end
      total++; if (dout !== 10'd0) begin bad++; $display("FAIL reset_dout got=%0d want=0", dout); end
      total++; if (warm !== 1'b1) begin bad++; $display("FAIL reset_warm got=%0b want=1", warm); end
      total++; if (ovf !== 1'b0 || peak !== 10'd0) begin bad++; $display("FAIL reset_ovf_peak got=%0b/%0d want=0/0", ovf, peak); end
   endtask

   task automatic test_warmup();
      y_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         Y = 10'(i);
         step();
         if (i == 7) begin
            total++; if (warm !== 1'b1) begin bad++; $display("FAIL warm_after7 got=%0b want=1", warm); end
         end
      end
      y_en = 1'b0;
      total++; if (warm !== 1'b0) begin bad++; $display("FAIL warm_after8 got=%0b want=0", warm); end
      total++; if (count !== 4'd0 || dout_valid !== 1'b0) begin bad++; $display("FAIL warm_count got=%0d/%0b want=0/0", count, dout_valid); end
      total++; if (peak !== 10'd0) begin bad++; $display("FAIL warm_peak got=%0d want=0", peak); end
   endtask

   task automatic test_basic();
      logic [9:0] vals [3] = '{10'd100, 10'd200, 10'd50};
      y_en = 1'b1; dout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Y = vals[i];
         step();
      end
      y_en = 1'b0;
      total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count); end
      total++; if (dout !== 10'd100 || dout_valid !== 1'b1) begin bad++; $display("FAIL basic_head got=%0d/%0b want=100/1", dout, dout_valid); end
      total++; if (peak !== 10'd200) begin bad++; $display("FAIL basic_peak got=%0d want=200", peak); end
      dout_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (dout !== vals[i]) begin bad++; $display("FAIL basic_drain%0d got=%0d want=%0d", i, dout, vals[i]); end
         step();
      end
      dout_ready = 1'b0;
      total++; if (count !== 4'd0 || dout_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0d/%0b want=0/0", count, dout_valid); end
   endtask

   task automatic test_overflow();
      y_en = 1'b1; dout_ready = 1'b0;
      for (int i = 10; i <= 18; i++) begin
         Y = 10'(i);
         step();
      end
      y_en = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf); end
      dout_ready = 1'b1;
      for (int i = 10; i <= 17; i++) begin
         total++; if (dout !== 10'(i) || dout_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain got=%0d/%0b want=%0d/1", dout, dout_valid, i); end
         step();
      end
      dout_ready = 1'b0;
      total++; if (count !== 4'd0 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_after got=%0d/%0b want=0/1", count, ovf); end
      total++; if (peak !== 10'd200) begin bad++; $display("FAIL ovf_peak got=%0d want=200", peak); end
   endtask

   task automatic test_full_push_pop();
      logic [9:0] want;
      apply_reset();
      run_warmup();
      y_en = 1'b1;
      for (int i = 10; i <= 17; i++) begin
         Y = 10'(i);
         step();
      end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_fill got=%0d want=8", count); end
      Y = 10'd999; dout_ready = 1'b1;
      step();
      y_en = 1'b0; dout_ready = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_pp_count got=%0d want=8", count); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_pp_ovf got=%0b want=0", ovf); end
      total++; if (dout !== 10'd11) begin bad++; $display("FAIL full_pp_head got=%0d want=11", dout); end
      total++; if (peak !== 10'd999) begin bad++; $display("FAIL full_pp_peak got=%0d want=999", peak); end
      dout_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         want = (i == 7) ? 10'd999 : 10'(11 + i);
         total++; if (dout !== want) begin bad++; $display("FAIL full_drain%0d got=%0d want=%0d", i, dout, want); end
         step();
      end
      dout_ready = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL full_empty got=%0d want=0", count); end
   endtask

   task automatic test_back_to_back();
      dout_ready = 1'b1; y_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         Y = 10'(300 + i);
         step();
         total++;
         if (dout !== 10'(300 + i) || count !== 4'd1 || dout_valid !== 1'b1) begin
            bad++; $display("FAIL stream%0d got=%0d/%0d/%0b want=%0d/1/1", i, dout, count, dout_valid, 300 + i);
         end
      end
      y_en = 1'b0;
      step();
      dout_ready = 1'b0;
      total++; if (count !== 4'd0 || dout_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%0d/%0b want=0/0", count, dout_valid); end
   endtask

   task automatic test_mid_reset();
      y_en = 1'b1; dout_ready = 1'b0;
      for (int i = 40; i <= 48; i++) begin
         Y = 10'(i);
         step();
      end
      y_en = 1'b0; dout_ready = 1'b1;
      step(); step(); step();
      total++; if (count !== 4'd5 || ovf !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%0b want=5/1", count, ovf); end
      y_en = 1'b1; Y = 10'd555; reset = 1'b0;
      step();
      total++; if (count !== 4'd0 || dout_valid !== 1'b0) begin bad++; $display("FAIL mid_count got=%0d/%0b want=0/0", count, dout_valid); end
      total++; if (ovf !== 1'b0 || peak !== 10'd0 || warm !== 1'b1) begin bad++; $display("FAIL mid_state got=%0b/%0d/%0b want=0/0/1", ovf, peak, warm); end
      reset = 1'b1; Y = 10'd900;
      for (int i = 1; i <= 8; i++) begin
         step();
         total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_warm%0d got=%0d want=0", i, count); end
      end
      total++; if (warm !== 1'b0) begin bad++; $display("FAIL mid_warm_end got=%0b want=0", warm); end
      Y = 10'd7;
      step();
      y_en = 1'b0; dout_ready = 1'b0;
      total++; if (count !== 4'd1 || dout !== 10'd7 || peak !== 10'd7) begin bad++; $display("FAIL mid_first got=%0d/%0d/%0d want=1/7/7", count, dout, peak); end
   endtask

   initial begin
      reset = 1'b0; y_en = 1'b0; dout_ready = 1'b0; Y = '0;
      test_reset();
      test_warmup();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
